// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: writeback-stage encodings shared by the control unit,
// the MEM/WB pipeline register and the register file.
//   wb_sel_e  : WB_sel_data encodings (ALU result, load data, PC+4, reserved)
//   REG_ZERO  : hard-wired zero register index
//   DATA_W / NUM_REGS / ADDR_W : fixed architectural sizes
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // A write lands only for a real destination and a defined source.
  function automatic logic wr_effective(input logic wr_en,
                                        input logic [ADDR_W-1:0] addr,
                                        input wb_sel_e sel);
    return wr_en && (addr != REG_ZERO) && (sel != SEL_RSVD);
  endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// wb_regfile_wb_mux: combinational 4:1 writeback source select.
//   sel    : writeback source select (wb_sel_e encoding)
//   alu    : ALU result
//   mem    : load data
//   pc4    : link return address
//   wrdata : selected value; reserved select yields zero
module wb_regfile_wb_mux
  import wb_regfile_pkg::*;
(
  input  wb_sel_e           sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] pc4,
  output logic [DATA_W-1:0] wrdata
);

  always_comb begin
    wrdata = '0;
    case (sel)
      SEL_ALU: wrdata = alu;
      SEL_MEM: wrdata = mem;
      SEL_PC4: wrdata = pc4;
      default: wrdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 register file with writeback source select and
// write-through bypass on all read ports.
//   clk, nrst              : clock, async active-low reset (clears all regs)
//   WB_wr_en, WB_sel_data  : writeback enable and source select
//   WB_ALUres/dataout/pc4  : writeback candidates from MEM/WB
//   WB_wraddr              : destination register
//   WB_wrdata              : selected writeback value (also for forwarding)
//   rd_addr1/2, rd_data1/2 : asynchronous ID-stage read ports
//   dbg_addr, dbg_data     : inspection port, same semantics as rd ports
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              WB_wr_en,
  input  logic [1:0]        WB_sel_data,
  input  logic [DATA_W-1:0] WB_ALUres,
  input  logic [DATA_W-1:0] WB_dataout,
  input  logic [DATA_W-1:0] WB_pc4,
  input  logic [ADDR_W-1:0] WB_wraddr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] WB_wrdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_RP = 3;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            wr_eff;
  logic [NUM_RP-1:0][ADDR_W-1:0]   rp_addr;
  logic [NUM_RP-1:0][DATA_W-1:0]   rp_data;

  wb_regfile_wb_mux u_wb_mux (
    .sel    (wb_sel_e'(WB_sel_data)),
    .alu    (WB_ALUres),
    .mem    (WB_dataout),
    .pc4    (WB_pc4),
    .wrdata (WB_wrdata)
  );

  assign wr_eff = wr_effective(WB_wr_en, WB_wraddr, wb_sel_e'(WB_sel_data));

  // Reset wins over a same-cycle write; reg 0 is never a legal target.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       regs <= '0;
    else if (wr_eff) regs[WB_wraddr] <= WB_wrdata;
  end

  assign rp_addr  = {dbg_addr, rd_addr2, rd_addr1};
  assign rd_data1 = rp_data[0];
  assign rd_data2 = rp_data[1];
  assign dbg_data = rp_data[2];

  // Each port bypasses independently; the bypass is gated off in reset so
  // nothing but zero is visible while nrst is low.
  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
    always_comb begin
      rp_data[p] = '0;
      if (!nrst)
        rp_data[p] = '0;
      else if (wr_eff && (WB_wraddr == rp_addr[p]))
        rp_data[p] = WB_wrdata;
      else if (rp_addr[p] != REG_ZERO)
        rp_data[p] = regs[rp_addr[p]];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        nrst;
  logic        WB_wr_en;
  logic [1:0]  WB_sel_data;
  logic [31:0] WB_ALUres, WB_dataout, WB_pc4;
  logic [4:0]  WB_wraddr, rd_addr1, rd_addr2, dbg_addr;
  logic [31:0] rd_data1, rd_data2, WB_wrdata, dbg_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk         (clk),
    .nrst        (nrst),
    .WB_wr_en    (WB_wr_en),
    .WB_sel_data (WB_sel_data),
    .WB_ALUres   (WB_ALUres),
    .WB_dataout  (WB_dataout),
    .WB_pc4      (WB_pc4),
    .WB_wraddr   (WB_wraddr),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .WB_wrdata   (WB_wrdata),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Hand-maintained expected contents, updated explicitly by each scenario.
  logic [31:0] exp_regs [32];

  task automatic dump_chk(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1 chk($sformatf("%s_r%0d", tag, i), dbg_data, exp_regs[i]);
    end
  endtask

  // Drive a write at the negedge, let it land at the posedge, then idle.
  task automatic do_write(input logic [1:0] sel, input logic [4:0] addr, input logic [31:0] val);
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = sel; WB_wraddr = addr;
    WB_ALUres = val; WB_dataout = val; WB_pc4 = val;
    @(posedge clk); #1;
    WB_wr_en = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; WB_wr_en = 1'b0; WB_sel_data = 2'b00;
    WB_ALUres = '0; WB_dataout = '0; WB_pc4 = '0; WB_wraddr = '0;
    rd_addr1 = '0; rd_addr2 = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;

    // Reset: everything reads zero, even with a write and bypass requested.
    repeat (2) @(posedge clk);
    @(negedge clk);
    WB_wr_en = 1'b1; WB_wraddr = 5'd4; WB_ALUres = 32'h0000_0BAD; rd_addr1 = 5'd4;
    #1 chk("rst_no_bypass", rd_data1, 32'h0);
    @(posedge clk); #1;
    WB_wr_en = 1'b0;
    dump_chk("rst");
    @(negedge clk) nrst = 1'b1;

    // ALU write with bypass, then stored value.
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = 2'b00; WB_ALUres = 32'hDEADBEEF; WB_wraddr = 5'd5; rd_addr1 = 5'd5;
    dbg_addr = 5'd5;
    #1 chk("alu_bypass", rd_data1, 32'hDEADBEEF);
    chk("alu_wrdata", WB_wrdata, 32'hDEADBEEF);
    chk("alu_dbg_bypass", dbg_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    WB_wr_en = 1'b0; WB_ALUres = 32'h0;
    #1 chk("alu_stored", rd_data1, 32'hDEADBEEF);
    exp_regs[5] = 32'hDEADBEEF;

    // Load-data write to r0 is discarded.
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = 2'b01; WB_dataout = 32'h12345678; WB_wraddr = 5'd0; rd_addr1 = 5'd0;
    #1 chk("r0_before", rd_data1, 32'h0);
    chk("mem_wrdata", WB_wrdata, 32'h12345678);
    @(posedge clk); #1;
    WB_wr_en = 1'b0;
    #1 chk("r0_after", rd_data1, 32'h0);
    dump_chk("r0wr");

    // PC+4 to r31, both ports bypass, then hold.
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = 2'b10; WB_pc4 = 32'h0040_0008; WB_wraddr = 5'd31;
    rd_addr1 = 5'd31; rd_addr2 = 5'd31;
    #1 chk("pc4_byp1", rd_data1, 32'h0040_0008);
    chk("pc4_byp2", rd_data2, 32'h0040_0008);
    @(posedge clk); #1;
    WB_wr_en = 1'b0; WB_pc4 = 32'h0;
    @(posedge clk); #1;
    chk("pc4_hold1", rd_data1, 32'h0040_0008);
    chk("pc4_hold2", rd_data2, 32'h0040_0008);
    exp_regs[31] = 32'h0040_0008;

    // Reserved select: no write, no bypass, zero wrdata.
    do_write(2'b00, 5'd7, 32'hA5A5A5A5);
    exp_regs[7] = 32'hA5A5A5A5;
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = 2'b11; WB_wraddr = 5'd7; WB_ALUres = 32'h1; rd_addr1 = 5'd7;
    #1 chk("rsvd_no_bypass", rd_data1, 32'hA5A5A5A5);
    chk("rsvd_wrdata", WB_wrdata, 32'h0);
    @(posedge clk); #1;
    WB_wr_en = 1'b0;
    #1 chk("rsvd_held", rd_data1, 32'hA5A5A5A5);
    dump_chk("rsvd");

    // Reset mid-cycle during a pending write: reset wins, write lost.
    do_write(2'b00, 5'd3, 32'h1);
    rd_addr1 = 5'd3;
    #1 chk("r3_set", rd_data1, 32'h1);
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = 2'b00; WB_wraddr = 5'd3; WB_ALUres = 32'hFF;
    #2 nrst = 1'b0;
    #1 chk("rst_r3_now", rd_data1, 32'h0);
    dbg_addr = 5'd31;
    #1 chk("rst_r31_now", dbg_data, 32'h0);
    @(posedge clk); #1;
    WB_wr_en = 1'b0;
    @(negedge clk) nrst = 1'b1;
    #1 chk("rst_r3_after", rd_data1, 32'h0);
    for (int i = 0; i < 32; i++) exp_regs[i] = '0;
    dump_chk("post_rst");

    // First rising edge after release accepts a write.
    @(negedge clk);
    WB_wr_en = 1'b1; WB_sel_data = 2'b00; WB_wraddr = 5'd9; WB_ALUres = 32'hCAFE_0009;
    @(posedge clk); #1;
    WB_wr_en = 1'b0; WB_ALUres = 32'h0;
    rd_addr2 = 5'd9;
    #1 chk("first_wr", rd_data2, 32'hCAFE_0009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
